// File: rtl/expand_int8.sv
// Streaming dequantizer: accepts a packed word of signed int8 lanes and emits one
// sign-extended, left-shifted fixed-point sample per cycle, lane 0 first.
module expand_int8_lane #(
    parameter int INPUT_WIDTH       = 8,
    parameter int OUTPUT_WIDTH      = 20,
    parameter int RADIX_POINT_RIGHT = 8
) (
    input  logic [INPUT_WIDTH-1:0]  i_sample,
    input  logic [1:0]              i_shift,
    output logic [OUTPUT_WIDTH-1:0] o_sample
);
    logic [OUTPUT_WIDTH-1:0] w_ext;

    // OUTPUT_WIDTH >= INPUT_WIDTH + RADIX_POINT_RIGHT + 3 keeps the shift lossless.
    assign w_ext    = {{(OUTPUT_WIDTH-INPUT_WIDTH){i_sample[INPUT_WIDTH-1]}}, i_sample};
    assign o_sample = (w_ext << RADIX_POINT_RIGHT) << i_shift;
endmodule

module expand_int8 #(
    parameter int INPUT_WIDTH       = 8,
    parameter int OUTPUT_WIDTH      = 20,
    parameter int RADIX_POINT_RIGHT = 8,
    parameter int LANES             = 4,
    localparam int LANE_W           = $clog2(LANES)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [LANES*INPUT_WIDTH-1:0] i_in_data,
    input  logic [1:0]                   i_in_shift,
    input  logic                         i_in_last,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [OUTPUT_WIDTH-1:0]      o_out_data,
    output logic                         o_out_last,
    output logic [LANE_W-1:0]            o_out_lane
);
    typedef enum logic {EMPTY = 1'b0, LOAD = 1'b1} state_t;

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic [LANES*INPUT_WIDTH-1:0]        r_word;
    logic [1:0]                          r_shift;
    logic                                r_last;
    logic [LANE_W-1:0]                   r_lane_cnt;
    logic [LANES-1:0][OUTPUT_WIDTH-1:0]  w_lane_data;
    logic                                w_last_lane;
    logic                                w_out_fire;
    logic                                w_accept;

    assign w_last_lane = (r_lane_cnt == LANE_W'(LANES-1));
    assign w_out_fire  = o_out_valid && i_out_ready;
    assign w_accept    = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= EMPTY;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_state_nxt = LOAD;
            LOAD:    if (w_out_fire && w_last_lane && !w_accept) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // in_ready looks through to out_ready so a new word lands on the last-lane cycle.
    always_comb begin
        o_out_valid = (r_state == LOAD);
        o_in_ready  = (r_state == EMPTY) || (i_out_ready && w_last_lane);
        o_out_last  = (r_state == LOAD) && r_last && w_last_lane;
        o_out_lane  = r_lane_cnt;
        o_out_data  = w_lane_data[r_lane_cnt];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_word     <= '0;
            r_shift    <= '0;
            r_last     <= 1'b0;
            r_lane_cnt <= '0;
        end else if (w_accept) begin
            r_word     <= i_in_data;
            r_shift    <= i_in_shift;
            r_last     <= i_in_last;
            r_lane_cnt <= '0;
        end else if (w_out_fire) begin
            r_lane_cnt <= w_last_lane ? '0 : r_lane_cnt + LANE_W'(1);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        expand_int8_lane #(
            .INPUT_WIDTH      (INPUT_WIDTH),
            .OUTPUT_WIDTH     (OUTPUT_WIDTH),
            .RADIX_POINT_RIGHT(RADIX_POINT_RIGHT)
        ) u_lane (
            .i_sample(r_word[g*INPUT_WIDTH +: INPUT_WIDTH]),
            .i_shift (r_shift),
            .o_sample(w_lane_data[g])
        );
    end
endmodule

// File: tb/tb_expand_int8.sv
// Bench for expand_int8: directed vectors plus randomized streams scored against a
// word-to-sample reference model.
module tb_expand_int8;
    localparam int IW    = 8;
    localparam int OW    = 20;
    localparam int RPR   = 8;
    localparam int LANES = 4;
    localparam int LCW   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, in_last;
    logic [LANES*IW-1:0] in_data;
    logic [1:0]        in_shift;
    logic              out_valid, out_ready, out_last;
    logic [OW-1:0]     out_data;
    logic [LCW-1:0]    out_lane;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    expand_int8 dut (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .i_in_shift(in_shift), .i_in_last(in_last),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_out_last(out_last), .o_out_lane(out_lane)
    );

    typedef struct packed {logic [OW-1:0] data; logic [LCW-1:0] lane; logic last;} samp_t;
    typedef struct packed {
        logic acc; logic in_ready; logic out_valid; logic out_ready; logic out_last;
        logic [LCW-1:0] lane; logic [OW-1:0] data;
    } tr_t;

    samp_t exp_q[$];
    samp_t obs_q[$];
    tr_t   trace_q[$];
    logic [LANES*IW-1:0] src_w[$];
    logic [1:0]          src_s[$];
    logic                src_l[$];

    // Reference: a signed byte scaled by 2^(RPR+shift), kept to OW bits.
    function automatic logic [OW-1:0] deq(input logic [IW-1:0] b, input logic [1:0] sh);
        int v;
        v = int'($signed(b)) * (1 << (RPR + int'(sh)));
        return v[OW-1:0];
    endfunction

    // Inverse stage: drop the fraction and saturate to int8.
    function automatic logic [IW-1:0] cutoff(input logic [OW-1:0] d);
        int v;
        v = int'($signed(d)) >>> RPR;
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
        return v[IW-1:0];
    endfunction

    task automatic model_word(input logic [LANES*IW-1:0] w, input logic [1:0] sh, input logic l);
        for (int k = 0; k < LANES; k++) begin
            samp_t s;
            s.data = deq(w[k*IW +: IW], sh);
            s.lane = LCW'(k);
            s.last = l && (k == LANES-1);
            exp_q.push_back(s);
        end
    endtask

    task automatic clear_all();
        exp_q.delete(); obs_q.delete(); trace_q.delete();
        src_w.delete(); src_s.delete(); src_l.delete();
    endtask

    // Driver/monitor only: feeds src_* words, logs every cycle, collects transfers.
    task automatic drive(input int rdy_pct, input int want, input int budget);
        int cyc = 0;
        while (obs_q.size() < want && cyc < budget) begin
            tr_t t;
            samp_t s;
            in_valid = (src_w.size() > 0);
            if (in_valid) begin
                in_data = src_w[0]; in_shift = src_s[0]; in_last = src_l[0];
            end else begin
                in_data = $urandom(); in_shift = 2'($urandom_range(3)); in_last = 1'($urandom_range(1));
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            t.acc = in_valid && in_ready; t.in_ready = in_ready; t.out_valid = out_valid;
            t.out_ready = out_ready; t.out_last = out_last; t.lane = out_lane; t.data = out_data;
            trace_q.push_back(t);
            if (t.acc) begin
                model_word(src_w[0], src_s[0], src_l[0]);
                void'(src_w.pop_front()); void'(src_s.pop_front()); void'(src_l.pop_front());
            end
            if (out_valid && out_ready) begin
                s.data = out_data; s.lane = out_lane; s.last = out_last;
                obs_q.push_back(s);
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0; in_last = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
        checks++; if (out_lane !== '0) begin errors++; $display("FAIL reset_out_lane got %0d want 0", out_lane); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midword();
        in_valid = 1'b1; in_data = $urandom(); in_shift = 2'd1; in_last = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midword_loaded got %b want 1", out_valid); end
        #3 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midword_async valid=%b last=%b ready=%b want 0/0/1", out_valid, out_last, in_ready);
        end
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin
                errors++; $display("FAIL midword_discard cyc=%0d valid=%b last=%b want 0/0", i, out_valid, out_last);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input logic [1:0] sh, input logic [OW-1:0] e0, input logic [OW-1:0] e1,
                              input logic [OW-1:0] e2, input logic [OW-1:0] e3);
        logic [OW-1:0] ev [4];
        ev = '{e0, e1, e2, e3};
        clear_all();
        src_w.push_back(32'h807F01FF); src_s.push_back(sh); src_l.push_back(1'b0);
        drive(100, 4, 40);
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL basic_count sh=%0d got %0d want 4", sh, obs_q.size()); end
        checks++; if (trace_q[0].acc !== 1'b1 || trace_q[1].out_valid !== 1'b1 || trace_q[1].lane !== '0) begin
            errors++; $display("FAIL basic_latency sh=%0d acc=%b next_valid=%b want 1/1", sh, trace_q[0].acc, trace_q[1].out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (obs_q[k].data !== ev[k] || obs_q[k].lane !== LCW'(k) || obs_q[k].last !== 1'b0
                          || trace_q[k+1].out_valid !== 1'b1) begin
                errors++; $display("FAIL basic_lane sh=%0d k=%0d got %h/%0d want %h/%0d", sh, k, obs_q[k].data, obs_q[k].lane, ev[k], k);
            end
        end
    endtask

    task automatic test_streaming();
        int f;
        clear_all();
        for (int w = 0; w < 3; w++) begin
            src_w.push_back($urandom()); src_s.push_back(2'($urandom_range(3))); src_l.push_back(w == 2);
        end
        drive(100, 12, 60);
        checks++; if (obs_q.size() != 12) begin errors++; $display("FAIL stream_count got %0d want 12", obs_q.size()); end
        f = 0;
        while (f < trace_q.size() && !trace_q[f].out_valid) f++;
        for (int k = 0; k < 12; k++) begin
            checks++; if (trace_q[f+k].out_valid !== 1'b1 || trace_q[f+k].in_ready !== (trace_q[f+k].lane == 2'd3)) begin
                errors++; $display("FAIL stream_cycle k=%0d valid=%b ready=%b lane=%0d", k, trace_q[f+k].out_valid, trace_q[f+k].in_ready, trace_q[f+k].lane);
            end
            checks++; if (obs_q[k] !== exp_q[k] || obs_q[k].last !== (k == 11)) begin
                errors++; $display("FAIL stream_sample k=%0d got %h/%0d/%b want %h/%0d/%b", k, obs_q[k].data, obs_q[k].lane, obs_q[k].last, exp_q[k].data, exp_q[k].lane, exp_q[k].last);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_all();
        for (int w = 0; w < 6; w++) begin
            src_w.push_back($urandom()); src_s.push_back(2'($urandom_range(3))); src_l.push_back(1'($urandom_range(1)));
        end
        drive(50, 24, 400);
        checks++; if (obs_q.size() != 24 || exp_q.size() != 24) begin
            errors++; $display("FAIL bp_count got %0d/%0d want 24", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL bp_sample k=%0d got %h/%0d/%b want %h/%0d/%b", k, obs_q[k].data, obs_q[k].lane, obs_q[k].last, exp_q[k].data, exp_q[k].lane, exp_q[k].last);
            end
        end
        for (int i = 0; i + 1 < trace_q.size(); i++) begin
            if (trace_q[i].out_valid && !trace_q[i].out_ready) begin
                checks++; if (trace_q[i+1].out_valid !== 1'b1 || trace_q[i+1].data !== trace_q[i].data
                              || trace_q[i+1].lane !== trace_q[i].lane || trace_q[i+1].out_last !== trace_q[i].out_last) begin
                    errors++; $display("FAIL bp_stall cyc=%0d got %h/%0d want %h/%0d", i, trace_q[i+1].data, trace_q[i+1].lane, trace_q[i].data, trace_q[i].lane);
                end
            end
            if (trace_q[i].acc && trace_q[i].out_valid) begin
                checks++; if (!(trace_q[i].out_ready && trace_q[i].lane == 2'd3)) begin
                    errors++; $display("FAIL bp_early_accept cyc=%0d lane=%0d ready=%b want lane 3 consumed", i, trace_q[i].lane, trace_q[i].out_ready);
                end
            end
        end
    endtask

    task automatic test_roundtrip();
        logic [IW-1:0] orig[$];
        clear_all();
        for (int j = 0; j < 64; j++) begin
            logic [LANES*IW-1:0] w;
            for (int k = 0; k < LANES; k++) begin
                int v;
                v = 4*j + k - 128;
                w[k*IW +: IW] = v[IW-1:0];
                orig.push_back(v[IW-1:0]);
            end
            src_w.push_back(w); src_s.push_back(2'd0); src_l.push_back(j == 63);
        end
        drive(80, 256, 1200);
        checks++; if (obs_q.size() != 256) begin errors++; $display("FAIL rt_count got %0d want 256", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++; if (cutoff(obs_q[i].data) !== orig[i]) begin
                errors++; $display("FAIL rt_value i=%0d got %h want %h", i, cutoff(obs_q[i].data), orig[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midword();
        test_basic(2'd0, 20'hFFF00, 20'h00100, 20'h07F00, 20'hF8000);
        test_basic(2'd3, 20'hFF800, 20'h00800, 20'h3F800, 20'hC0000);
        test_streaming();
        test_backpressure();
        test_roundtrip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/expand_int8.md
# expand_int8

Streaming dequantizer for the conv datapath, the inverse of `cutoff`. It accepts packed words of signed 8-bit samples, `lanes` per word. For each lane it emits one sign-extended fixed-point sample per cycle in the accumulator format (`output_width` bits, `radix_point_right` fractional bits). It sits between the int8 feature/weight memory read port and the MAC array inputs, with valid/ready handshakes on both sides.

## Interface
- `input_width`, 8, bits per packed sample (signed two's complement integer).
- `output_width`, 20, bits per output sample (signed fixed point).
- `radix_point_right`, 8, fractional bits of the output format.
- `lanes`, 4, samples per input word.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  `lanes*input_width`  packed samples; lane 0 = bits [`input_width`-1:0].
- `in_shift`  in  2  extra left shift (0..3) applied to every lane of this word.
- `in_last`  in  1  word is the final word of a tile.
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  downstream accepts the sample.
- `out_data`  out  `output_width`  dequantized sample.
- `out_last`  out  1  final lane of a word that was marked `in_last`.
- `out_lane`  out  `$clog2(lanes)`  lane index of the current sample.

## Operation
- State: `word_q`, `shift_q`, `last_q`, `lane_cnt`, and `busy`.
- Two-state FSM:
  - EMPTY (`busy`=0): transfers to LOAD when a word is accepted.
  - LOAD (`busy`=1): holds a word and emits its lanes.
- Acceptance occurs on `in_valid && in_ready`. On acceptance:
  - the word, `in_shift` and `in_last` are captured;
  - `lane_cnt`←0;
  - `busy`←1.
- `in_ready` = !`busy` || (`out_ready` && `lane_cnt`==`lanes`-1). The path is combinational from `out_ready`, so back-to-back words stream with no bubble.
- `out_valid` = `busy`.
- `out_data` = sign_extend(`word_q` lane `lane_cnt`) << (`radix_point_right` + `shift_q`), computed at full `output_width`.
- Width rule: `output_width` ≥ `input_width` + `radix_point_right` + 3. Under this rule no overflow and no saturation are possible. At the defaults the worst case is 8+8+3 = 19 bits ≤ 20.
- `out_lane` = `lane_cnt`.
- `out_last` = `busy` && `last_q` && `lane_cnt`==`lanes`-1.
- On an output transfer (`out_valid` && `out_ready`):
  - if `lane_cnt` < `lanes`-1: `lane_cnt`+1;
  - else if a new word is accepted in the same cycle: reload it;
  - else: `busy`←0, `lane_cnt`←0.
- When `out_ready`=0, all outputs hold stable and `in_data` is ignored.
- Lane order is ascending (lane 0 first).
- Round-trip property: with `in_shift`=0, feeding `out_data` into `cutoff` reproduces the original byte for every value in -128..127.

## Timing
- Reset (async assert, sync release on the next edge), all outputs and state zero:
  - `busy`=0, `lane_cnt`=0, `word_q`=0, `shift_q`=0, `last_q`=0;
  - `out_valid`=0, `out_data`=0, `out_last`=0, `out_lane`=0;
  - `in_ready`=1.
- Latency: a word accepted at edge N presents lane 0 in the cycle after N.
- Lane k of a word is presented no earlier than N+k cycles later. This is exact when `out_ready`=1 throughout.
- Throughput: 1 sample/cycle sustained, i.e. `lanes` cycles per word.
- `in_ready` is low during cycles where `busy`=1 and the last lane is not being consumed. Any `in_valid` in those cycles is not accepted and must be held by the source.
- Reset mid-word: the remaining lanes are discarded, `out_valid` drops immediately, and no `out_last` is emitted.
- `in_shift` and `in_last` are sampled only at acceptance. Changes while `busy` have no effect.

## Test plan
- Reset with `in_valid`=0:
  - all outputs 0, `in_ready`=1;
  - assert `rst` asynchronously mid-cycle and check `out_valid` falls before the next edge.
- Basic word: `in_data`=32'h807F01FF, shift 0, `out_ready`=1.
  - Outputs 20'hFFF00, 20'h00100, 20'h07F00, 20'hF8000 on 4 consecutive cycles.
  - `out_lane` 0..3.
- Shift: same word with `in_shift`=3.
  - Outputs 20'hFF800, 20'h00800, 20'h3F800, 20'hC0000.
- Streaming: 3 back-to-back words, last one with `in_last`=1, `out_ready`=1.
  - 12 consecutive valid samples, no bubbles.
  - `in_ready` high only on lane-3 cycles.
  - `out_last` only on sample 12.
- Backpressure: toggle `out_ready` pseudo-randomly.
  - `out_data` is stable while stalled.
  - No sample is lost or duplicated, checked against a reference queue.
  - Second word not accepted until lane 3 of the first is consumed.
- Round trip: sweep bytes -128..127 through `expand_int8` then `cutoff`, with shift 0. Output equals input for all 256 values.
